// File: rtl/core_fetch_pkg.sv
// Shared fetch-path types and constants, also used by the decoder and branch unit.
package core_fetch_pkg;

    localparam int FETCH_ADDR_W  = 32;
    localparam int FETCH_INSTR_W = 32;

    localparam int unsigned DEFAULT_PC_STEP  = 4;
    localparam int unsigned DEFAULT_RESET_PC = 0;

    // One fetched instruction together with the address it was fetched from.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Width of a counter that must hold every value from 0 up to and including depth.
    function automatic int ctr_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bus: instruction-memory request/response, redirect from execute,
// and the valid/ready handshake towards the decoder.
interface fetch_queue_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0]  dec_pc;
    logic               protocol_err;

    // The fetch unit itself.
    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output dec_valid, dec_instr, dec_pc,
        input  dec_ready,
        output protocol_err
    );

    // Memory, execute and decoder as seen from the fetch unit.
    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  dec_valid, dec_instr, dec_pc,
        output dec_ready,
        input  protocol_err
    );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with clear, occupancy count and combinational head read.
module fetch_fifo
    import core_fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int CNT_W = ctr_width(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Clear wins over push and pop; pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push  = push && !clear;
        do_pop   = pop && !clear && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: credit-limited request/grant fetching into a small queue
// feeding the decoder, with redirect flushing and discarding of stale responses.
module fetch_queue_unit
    import core_fetch_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          INSTR_W  = 32,
    parameter int          DEPTH    = 4,
    parameter int unsigned PC_STEP  = DEFAULT_PC_STEP,
    parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
    input logic               clk,
    input logic               rst,
    fetch_queue_unit_if.master bus
);

    localparam int                CNT_W = ctr_width(DEPTH);
    localparam int                OCC_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] PC0   = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic              protocol_err_q, protocol_err_d;

    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          live;
    logic [OCC_W-1:0]          occupancy;
    logic                      req;
    logic                      grant;
    logic                      resp_ok;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      dec_v;
    logic [ADDR_W+INSTR_W-1:0] head;

    // Credits: queued words plus live in-flight words may never exceed the queue size.
    always_comb begin
        live      = inflight_q - discard_q;
        occupancy = {1'b0, count} + {1'b0, live};
        req       = !rst && !bus.redirect_valid && (occupancy < OCC_W'(DEPTH))
                    && (inflight_q < CNT_W'(DEPTH));
        grant     = req && bus.imem_gnt;
        resp_ok   = bus.imem_rvalid && (inflight_q != '0);
        fifo_push = resp_ok && !bus.redirect_valid && (discard_q == '0);
        dec_v     = (count != '0) && !bus.redirect_valid;
        fifo_pop  = dec_v && bus.dec_ready;
    end

    // Next-state of the PCs and counters; a redirect overrides normal advance.
    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        resp_pc_d      = resp_pc_q;
        discard_d      = discard_q;
        protocol_err_d = protocol_err_q | (bus.imem_rvalid && (inflight_q == '0));
        inflight_d     = inflight_q + CNT_W'(grant) - CNT_W'(resp_ok);
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            resp_pc_d  = bus.redirect_pc;
            discard_d  = inflight_q - CNT_W'(resp_ok);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + STEP;
            end
            if (resp_ok) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CNT_W'(1);
                end else begin
                    resp_pc_d = resp_pc_q + STEP;
                end
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q     <= PC0;
            resp_pc_q      <= PC0;
            inflight_q     <= '0;
            discard_q      <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            resp_pc_q      <= resp_pc_d;
            inflight_q     <= inflight_d;
            discard_q      <= discard_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    fetch_fifo #(
        .WIDTH(ADDR_W + INSTR_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .clear    (bus.redirect_valid),
        .push_data({resp_pc_q, bus.imem_rdata}),
        .head_data(head),
        .count    (count)
    );

    assign bus.imem_req     = req;
    assign bus.imem_addr    = fetch_pc_q;
    assign bus.dec_valid    = dec_v;
    assign bus.dec_pc       = head[ADDR_W+INSTR_W-1 -: ADDR_W];
    assign bus.dec_instr    = head[INSTR_W-1:0];
    assign bus.protocol_err = protocol_err_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Testbench for fetch_queue_unit: a variable-latency in-order memory plus a queue-based
// model of which fetched words the decoder must see, in which order and when.
module tb_fetch_queue_unit;

    localparam int DEPTH = 4;
    localparam int STEP  = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } flight_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_queue_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    fetch_queue_unit #(
        .ADDR_W  (32),
        .INSTR_W (32),
        .DEPTH   (DEPTH),
        .PC_STEP (STEP),
        .RESET_PC(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    flight_t     flight[$];
    exp_t        expq[$];
    logic [31:0] next_addr;
    bit          err_exp;
    int          cyc;
    int          last_due;
    int          vectors;
    int          miscompares;

    bit          obs_req;
    bit          obs_dec_valid;
    bit          obs_err;
    logic [31:0] obs_addr;
    logic [31:0] obs_dec_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_clear();
        flight.delete();
        expq.delete();
        next_addr = 32'h0;
        err_exp   = 1'b0;
        cyc       = 0;
        last_due  = -1;
    endtask

    task automatic drive_idle();
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.dec_ready      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock of stimulus: memory responses from the in-flight list, model update, checks.
    task automatic cycle(input bit gnt, input int lat, input bit ready,
                         input bit redir, input logic [31:0] rpc, input bit spurious);
        bit      rv;
        bit      req_exp;
        bit      dv_exp;
        int      live;
        int      due;
        flight_t f;
        @(negedge clk);
        rv = ((flight.size() != 0) && (flight[0].due <= cyc)) || spurious;
        bus.imem_gnt       = gnt;
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = (!spurious && flight.size() != 0) ? mem_word(flight[0].addr) : $urandom;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.dec_ready      = ready;
        #1;
        obs_req       = bus.imem_req;
        obs_dec_valid = bus.dec_valid;
        obs_err       = bus.protocol_err;
        obs_addr      = bus.imem_addr;
        obs_dec_pc    = bus.dec_pc;

        live = 0;
        foreach (flight[i]) if (!flight[i].stale) live++;
        req_exp = !redir && (expq.size() + live < DEPTH) && (flight.size() < DEPTH);
        dv_exp  = (expq.size() != 0) && !redir;

        vectors++;
        if (bus.imem_req !== req_exp) begin
            miscompares++;
            $display("[TB] FAIL imem_req cyc=%0d got=%b exp=%b", cyc, bus.imem_req, req_exp);
        end
        vectors++;
        if (bus.imem_addr !== next_addr) begin
            miscompares++;
            $display("[TB] FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, next_addr);
        end
        vectors++;
        if (bus.dec_valid !== dv_exp) begin
            miscompares++;
            $display("[TB] FAIL dec_valid cyc=%0d got=%b exp=%b", cyc, bus.dec_valid, dv_exp);
        end
        vectors++;
        if (bus.protocol_err !== err_exp) begin
            miscompares++;
            $display("[TB] FAIL protocol_err cyc=%0d got=%b exp=%b", cyc, bus.protocol_err, err_exp);
        end

        if (dv_exp && ready) begin
            vectors++;
            if (bus.dec_pc !== expq[0].pc || bus.dec_instr !== expq[0].instr) begin
                miscompares++;
                $display("[TB] FAIL dec_word cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                         cyc, bus.dec_pc, bus.dec_instr, expq[0].pc, expq[0].instr);
            end
            void'(expq.pop_front());
        end

        if (rv) begin
            if (flight.size() == 0) begin
                err_exp = 1'b1;
            end else begin
                f = flight.pop_front();
                if (!f.stale && !redir) expq.push_back('{f.addr, mem_word(f.addr)});
            end
        end

        if (redir) begin
            expq.delete();
            foreach (flight[i]) flight[i].stale = 1'b1;
            next_addr = rpc;
        end else if (req_exp && gnt) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            flight.push_back('{next_addr, due, 1'b0});
            last_due  = due;
            next_addr = next_addr + STEP;
        end
        cyc++;
    endtask

    // Asynchronous reset in the middle of traffic clears everything immediately.
    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 2, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        model_clear();
        #1;
        vectors++;
        if (bus.imem_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_req got=%b exp=0", bus.imem_req);
        end
        vectors++;
        if (bus.dec_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_dec_valid got=%b exp=0", bus.dec_valid);
        end
        vectors++;
        if (bus.imem_addr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_addr got=%h exp=0", bus.imem_addr);
        end
        vectors++;
        if (bus.protocol_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_err got=%b exp=0", bus.protocol_err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Streaming with one-cycle memory: first word two cycles after first grant, then no gaps.
    task automatic test_stream();
        int          first_grant;
        int          first_valid;
        int          bubbles;
        logic [31:0] exp_pc;
        do_reset();
        first_grant = -1;
        first_valid = -1;
        bubbles     = 0;
        exp_pc      = 32'h0;
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 1, 1'b1, 1'b0, '0, 1'b0);
            if (first_grant < 0 && obs_req) first_grant = i;
            if (first_valid < 0 && obs_dec_valid) first_valid = i;
            if (obs_dec_valid) begin
                vectors++;
                if (obs_dec_pc !== exp_pc) begin
                    miscompares++;
                    $display("[TB] FAIL stream_pc got=%h exp=%h", obs_dec_pc, exp_pc);
                end
                exp_pc = exp_pc + STEP;
            end
            if (i >= 4 && !obs_dec_valid) bubbles++;
        end
        vectors++;
        if (first_grant < 0 || first_valid - first_grant != 2) begin
            miscompares++;
            $display("[TB] FAIL stream_latency got=%0d exp=2", first_valid - first_grant);
        end
        vectors++;
        if (bubbles != 0) begin
            miscompares++;
            $display("[TB] FAIL stream_bubbles got=%0d exp=0", bubbles);
        end
    endtask

    // Decoder stalled: fetching stops at DEPTH words, none are lost once it resumes.
    task automatic test_backpressure();
        int          grants;
        int          popped;
        logic [31:0] exp_pc;
        do_reset();
        grants = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1, 1'b0, 1'b0, '0, 1'b0);
            if (obs_req) grants++;
        end
        vectors++;
        if (grants != DEPTH) begin
            miscompares++;
            $display("[TB] FAIL bp_grants got=%0d exp=%0d", grants, DEPTH);
        end
        vectors++;
        if (obs_dec_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_valid_held got=%b exp=1", obs_dec_valid);
        end
        popped = 0;
        exp_pc = 32'h0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1, 1'b1, 1'b0, '0, 1'b0);
            if (obs_dec_valid) begin
                vectors++;
                if (obs_dec_pc !== exp_pc) begin
                    miscompares++;
                    $display("[TB] FAIL bp_pc got=%h exp=%h", obs_dec_pc, exp_pc);
                end
                exp_pc = exp_pc + STEP;
                popped++;
            end
        end
        vectors++;
        if (popped != DEPTH) begin
            miscompares++;
            $display("[TB] FAIL bp_popped got=%0d exp=%0d", popped, DEPTH);
        end
    endtask

    // Grant withheld: the request address holds and only advances when granted.
    task automatic test_gnt_stall();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1, 1'b1, 1'b0, '0, 1'b0);
            vectors++;
            if (obs_addr !== 32'h10 || obs_req !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL stall_addr got=%h req=%b exp=00000010 req=1", obs_addr, obs_req);
            end
        end
        cycle(1'b1, 1, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1, 1'b1, 1'b0, '0, 1'b0);
        vectors++;
        if (obs_addr !== 32'h14) begin
            miscompares++;
            $display("[TB] FAIL stall_advance got=%h exp=00000014", obs_addr);
        end
    endtask

    // Wait for the first delivered word after a redirect and compare its PC.
    task automatic expect_first_pc(input logic [31:0] pc, input int lat);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle(1'b1, lat, 1'b1, 1'b0, '0, 1'b0);
            if (obs_dec_valid) seen = 1'b1;
        end
        vectors++;
        if (!seen || obs_dec_pc !== pc) begin
            miscompares++;
            $display("[TB] FAIL redirect_first_pc seen=%b got=%h exp=%h", seen, obs_dec_pc, pc);
        end
    endtask

    // Redirect with three slow requests outstanding: all three responses are dropped.
    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 4, 1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 4, 1'b1, 1'b1, 32'h100, 1'b0);
        vectors++;
        if (obs_dec_valid !== 1'b0 || obs_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL redirect_cycle got valid=%b req=%b exp 0 0", obs_dec_valid, obs_req);
        end
        expect_first_pc(32'h100, 4);
    endtask

    // Redirect in the same cycle as a response and a ready decoder with a non-empty queue.
    task automatic test_redirect_rvalid();
        bit rv_seen;
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 2, 1'b1, 1'b0, '0, 1'b0);
        rv_seen = (flight.size() != 0) && (flight[0].due <= cyc);
        cycle(1'b1, 2, 1'b1, 1'b1, 32'h200, 1'b0);
        vectors++;
        if (!rv_seen || obs_dec_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL redirect_rvalid got valid=%b rvalid=%b exp valid=0 rvalid=1", obs_dec_valid, rv_seen);
        end
        expect_first_pc(32'h200, 2);
    endtask

    // Response with nothing in flight sets a sticky error and leaves the queue alone.
    task automatic test_protocol_err();
        do_reset();
        cycle(1'b0, 1, 1'b1, 1'b0, '0, 1'b1);
        cycle(1'b0, 1, 1'b1, 1'b0, '0, 1'b0);
        vectors++;
        if (obs_err !== 1'b1 || obs_dec_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL perr_set got err=%b valid=%b exp err=1 valid=0", obs_err, obs_dec_valid);
        end
        for (int i = 0; i < 10; i++) cycle(1'b1, 1, 1'b1, 1'b0, '0, 1'b0);
        vectors++;
        if (obs_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL perr_sticky got=%b exp=1", obs_err);
        end
        do_reset();
        vectors++;
        if (bus.protocol_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL perr_cleared got=%b exp=0", bus.protocol_err);
        end
    endtask

    // Random grant, latency, ready and redirects, including PC wrap and a mid-run reset.
    task automatic test_random();
        logic [31:0] rpc;
        bit          redir;
        do_reset();
        for (int i = 0; i < 700; i++) begin
            if (i == 350) do_reset();
            redir = ($urandom_range(0, 99) < 4);
            rpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            cycle($urandom_range(0, 3) != 0, $urandom_range(1, 5),
                  $urandom_range(0, 9) < 7, redir, rpc, 1'b0);
        end
    endtask

    // Bound on total run time.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] timeout");
    end

    // Test sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        drive_idle();
        model_clear();
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect();
        test_redirect_rvalid();
        test_protocol_err();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
